reg_bank_mc: RTL

- Next-generation, system-side register bank for the bilinear DSA debug path. It sits downstream of the vJTAG CDC front end and runs entirely in clk_sys.
- It accepts single-beat read/write requests and drives the core configuration and start pulse.
- It exposes NCH parametrised BRAM read channels, each with its own address pointer. It adds a memory-latency-aware read FSM and a sticky done flag with W1C clear.

---
 rtl/reg_bank_mc.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/reg_bank_mc.sv
// -----------------------------------------------------------------------------
// reg_bank_mc
//   System-side register bank for the bilinear DSA debug path (clk_sys only).
//   Accepts single-beat read/write requests, drives the core configuration
//   and start pulse, exposes NCH BRAM read channels with per-channel address
//   pointers, and keeps a sticky done flag with write-1-to-clear.
//
// Optional build macro:
//   REG_BANK_AUTOINC_EN  - CONTROL bit1 is stored and readable. When it is
//                          set, every completed DATA_ch read advances PTR_ch
//                          by one (wrapping modulo 2^AW). Without the macro,
//                          pointers move only on explicit writes and CONTROL
//                          reads return DEADBEEF.
//
// Ports:
//   clk_sys, rst_sys_n       clock, synchronous active-low reset
//   req_valid/req_ready      request handshake
//   req_write, req_addr      1=write / 0=read, 8-bit register address
//   req_wdata [DW]           write data
//   rsp_valid, rsp_rdata     one-cycle read response strobe and held data
//   start_pulse              core start, high for START_W cycles
//   cfg_in_w/in_h/scale_q88  core configuration (low 16 bits of registers)
//   status_done              core done level
//   mem_raddr [NCH*AW]       per-channel BRAM address, ch at [ch*AW +: AW]
//   mem_rdata [NCH*8]        per-channel BRAM byte, ch at [ch*8 +: 8]
//   dbg_state [2]            current FSM state (0=IDLE, 1=WAIT_MEM, 2=RESP)
//
// Handshake: a request transfers on a clk_sys edge where req_valid and
// req_ready are both 1; req_ready does not depend on req_valid. A read
// produces exactly one rsp_valid cycle with no backpressure; rsp_rdata keeps
// its value until the next response.
// -----------------------------------------------------------------------------
module reg_bank_mc #(
    parameter int DW      = 32,
    parameter int AW      = 12,
    parameter int NCH     = 2,
    parameter int MEM_LAT = 1,
    parameter int START_W = 8
) (
    input  logic              clk_sys,
    input  logic              rst_sys_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [7:0]        req_addr,
    input  logic [DW-1:0]     req_wdata,
    output logic              rsp_valid,
    output logic [DW-1:0]     rsp_rdata,
    output logic              start_pulse,
    output logic [15:0]       cfg_in_w,
    output logic [15:0]       cfg_in_h,
    output logic [15:0]       cfg_scale_q88,
    input  logic              status_done,
    output logic [NCH*AW-1:0] mem_raddr,
    input  logic [NCH*8-1:0]  mem_rdata,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_MEM = 2'd1,
        ST_RESP     = 2'd2
    } state_t;

    localparam logic [7:0]    A_CONTROL = 8'h00;
    localparam logic [7:0]    A_IN_W    = 8'h01;
    localparam logic [7:0]    A_IN_H    = 8'h02;
    localparam logic [7:0]    A_SCALE   = 8'h03;
    localparam logic [7:0]    A_STATUS  = 8'h10;
    localparam logic [DW-1:0] DEAD_VAL  = DW'(32'hDEADBEEF);
    localparam logic [3:0]    NCH_L     = 4'(NCH);

    state_t         state_q, state_d;

    logic [DW-1:0]  in_w_q, in_h_q, scale_q;
    logic [AW-1:0]  ptr_q [NCH];
    logic           done_seen_q;
    logic [7:0]     start_cnt_q;
    logic [2:0]     lat_cnt_q;
    logic [3:0]     rd_ch_q;
    logic           rsp_from_mem_q;
    logic [DW-1:0]  rsp_rdata_q;
    logic           autoinc_en;

`ifdef REG_BANK_AUTOINC_EN
    logic [1:0]     ctrl_q;
    assign autoinc_en = ctrl_q[1];
`else
    // Pointers only move on explicit writes.
    assign autoinc_en = 1'b0;
`endif

    // Address decode. Channel registers live at 0x20 + 0x10*ch; the upper
    // nibble minus two is the channel index.
    logic [3:0]     ch_idx;
    logic           ch_hit, is_ptr, is_data;
    logic           acc, wr_acc, rd_acc;

    assign ch_idx  = req_addr[7:4] - 4'd2;
    assign ch_hit  = (req_addr[7:4] >= 4'd2) && (ch_idx < NCH_L);
    assign is_ptr  = ch_hit && (req_addr[3:0] == 4'h0);
    assign is_data = ch_hit && (req_addr[3:0] == 4'h1);

    assign acc    = req_valid && req_ready;
    assign wr_acc = acc && req_write;
    assign rd_acc = acc && !req_write;

    // Register read mux for non-DATA reads (DATA comes from the BRAM later).
    logic [AW-1:0]  sel_ptr;
    logic [DW-1:0]  rd_val;

    always_comb begin
        sel_ptr = '0;
        for (int c = 0; c < NCH; c++) begin
            if (ch_idx == 4'(c)) sel_ptr = ptr_q[c];
        end

        rd_val = DEAD_VAL;
        if (req_addr == A_IN_W) begin
            rd_val = in_w_q;
        end else if (req_addr == A_IN_H) begin
            rd_val = in_h_q;
        end else if (req_addr == A_SCALE) begin
            rd_val = scale_q;
        end else if (req_addr == A_STATUS) begin
            rd_val    = '0;
            rd_val[1] = done_seen_q;
            rd_val[0] = status_done;
        end else if (is_ptr) begin
            rd_val = DW'(sel_ptr);
        end
`ifdef REG_BANK_AUTOINC_EN
        if (req_addr == A_CONTROL) rd_val = DW'(ctrl_q);
`endif
    end

    // Byte of the channel being read, captured when the latency count expires.
    logic [7:0] mem_byte;

    always_comb begin
        mem_byte = '0;
        for (int c = 0; c < NCH; c++) begin
            if (rd_ch_q == 4'(c)) mem_byte = mem_rdata[c*8 +: 8];
        end
    end

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk_sys) begin
        if (!rst_sys_n) state_q <= ST_IDLE;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                req_ready = rst_sys_n;
                if (rd_acc) state_d = is_data ? ST_WAIT_MEM : ST_RESP;
            end
            ST_WAIT_MEM: begin
                // Count 1 means this edge is the MEM_LAT-th since the accept.
                if (lat_cnt_q == 3'd1) state_d = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ----------------------------------------------------------- datapath
    always_ff @(posedge clk_sys) begin
        if (!rst_sys_n) begin
            in_w_q         <= DW'(64);
            in_h_q         <= DW'(64);
            scale_q        <= DW'(205);
            done_seen_q    <= 1'b0;
            start_cnt_q    <= '0;
            lat_cnt_q      <= '0;
            rd_ch_q        <= '0;
            rsp_from_mem_q <= 1'b0;
            rsp_rdata_q    <= '0;
            for (int c = 0; c < NCH; c++) ptr_q[c] <= '0;
`ifdef REG_BANK_AUTOINC_EN
            ctrl_q         <= '0;
`endif
        end else begin
            // A start write reloads the counter, so a re-write extends the pulse.
            if (wr_acc && req_addr == A_CONTROL && req_wdata[0])
                start_cnt_q <= 8'(START_W);
            else if (start_cnt_q != 8'd0)
                start_cnt_q <= start_cnt_q - 8'd1;

            // Set has priority over the write-1-to-clear.
            if (status_done)
                done_seen_q <= 1'b1;
            else if (wr_acc && req_addr == A_STATUS && req_wdata[1])
                done_seen_q <= 1'b0;

            if (wr_acc) begin
                case (req_addr)
                    A_IN_W:    in_w_q  <= req_wdata;
                    A_IN_H:    in_h_q  <= req_wdata;
                    A_SCALE:   scale_q <= req_wdata;
`ifdef REG_BANK_AUTOINC_EN
                    A_CONTROL: ctrl_q  <= req_wdata[1:0];
`endif
                    default: ;
                endcase
            end

            // No write can be accepted in RESP, so the two updates never meet.
            for (int c = 0; c < NCH; c++) begin
                if (wr_acc && is_ptr && ch_idx == 4'(c))
                    ptr_q[c] <= req_wdata[AW-1:0];
                else if (state_q == ST_RESP && rsp_from_mem_q && autoinc_en &&
                         rd_ch_q == 4'(c))
                    ptr_q[c] <= ptr_q[c] + AW'(1);
            end

            if (rd_acc) begin
                rsp_from_mem_q <= is_data;
                rd_ch_q        <= ch_idx;
                lat_cnt_q      <= 3'(MEM_LAT);
                if (!is_data) rsp_rdata_q <= rd_val;
            end else if (state_q == ST_WAIT_MEM) begin
                lat_cnt_q <= lat_cnt_q - 3'd1;
                if (lat_cnt_q == 3'd1) rsp_rdata_q <= DW'(mem_byte);
            end
        end
    end

    // ------------------------------------------------------------ outputs
    assign rsp_rdata     = rsp_rdata_q;
    assign start_pulse   = (start_cnt_q != 8'd0);
    assign cfg_in_w      = in_w_q[15:0];
    assign cfg_in_h      = in_h_q[15:0];
    assign cfg_scale_q88 = scale_q[15:0];
    assign dbg_state     = state_q;

    for (genvar g = 0; g < NCH; g++) begin : g_raddr
        assign mem_raddr[g*AW +: AW] = ptr_q[g];
    end

endmodule
